char_glyph_fetch: RTL

//  Upstream stage of the character region renderer. When the renderer pulses readEn it

---
 rtl/char_pkg.sv | 19 +
 rtl/char_glyph_fetch.sv | 130 +++++++++++++
 2 files changed

// File: rtl/char_pkg.sv
// Shared types and constants for the character glyph fetch stage.
// The FETCH_TIMEOUT_EN build option adds a romReq abort counter in char_glyph_fetch.
package char_pkg;

  localparam int unsigned CHAR_CODE_W   = 8;
  localparam int unsigned GLYPH_ROW_W   = 4;
  localparam int unsigned GLYPH_H       = 16;
  localparam int unsigned GLYPH_W       = 8;
  localparam int unsigned FONT_ADDR_W   = CHAR_CODE_W + GLYPH_ROW_W;
  localparam int unsigned COL_W         = 4;
  localparam int unsigned FETCH_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/char_glyph_fetch.sv
// Fetches one glyph row per renderer line over a req/ack font-memory handshake and
// serves the addressed pixel. Define FETCH_TIMEOUT_EN to abort fetches that never get acked.
module char_glyph_fetch
  import char_pkg::*;
#(
  parameter int unsigned CODE_W = CHAR_CODE_W,
  parameter int unsigned ROW_W  = GLYPH_ROW_W,
  parameter int unsigned CHAR_W = GLYPH_W
`ifdef FETCH_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = FETCH_TIMEOUT
`endif
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    readEn,
  input  logic [ROW_W-1:0]        rowCnt,
  input  logic [COL_W-1:0]        colCnt,
  input  logic [CODE_W-1:0]       charCode,
  output logic                    romReq,
  output logic [CODE_W+ROW_W-1:0] romAddr,
  input  logic                    romAck,
  input  logic [CHAR_W-1:0]       romData,
  output logic                    bitDisp,
  output logic                    fetchErr
);

  localparam int unsigned ADDR_W = CODE_W + ROW_W;
  localparam int unsigned IDX_W  = $clog2(CHAR_W);

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CHAR_W-1:0]   row_buf_q, row_buf_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                bit_q, bit_d;
  logic [IDX_W-1:0]    pix_idx;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // MSB of the row is the leftmost pixel, so column 0 maps to bit CHAR_W-1
  assign pix_idx = IDX_W'(CHAR_W - 1) - IDX_W'(colCnt);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      addr_q    <= '0;
      row_buf_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      bit_q     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      row_buf_q <= row_buf_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      bit_q     <= bit_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    row_buf_d = row_buf_q;
    valid_d   = valid_q;
    err_d     = err_q;
    bit_d     = valid_q && (32'(colCnt) < CHAR_W) && row_buf_q[pix_idx];
`ifdef FETCH_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      IDLE, HOLD: begin
        if (readEn) begin
          state_d = FETCH;
          addr_d  = {charCode, rowCnt};
          req_d   = 1'b1;
          valid_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      FETCH: begin
        // A new line request while the previous row is still in flight is an overrun
        if (readEn) begin
          err_d = 1'b1;
        end
        if (romAck) begin
          row_buf_d = romData;
          valid_d   = 1'b1;
          req_d     = 1'b0;
          state_d   = HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign romReq   = req_q;
  assign romAddr  = addr_q;
  assign bitDisp  = bit_q;
  assign fetchErr = err_q;

endmodule
